// File: rtl/fht_pkg.sv
// Shared types and constants for the FHT input loader.
// Build option FHT_LOAD_BITREV_EN selects bit-reversed bank/address order.
package fht_pkg;

   typedef enum logic [1:0] {LOAD, KICK, WAIT_BUSY, WAIT_DONE} loader_state_t;

   localparam int START_RETRY = 8;
   localparam int DROP_MAX    = 255;

   // Reverse the low 'width' bits of n; bits above width come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] n, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) r = r | (32'(n[i]) << (width - 1 - i));
      end
      return r;
   endfunction

endpackage

// File: rtl/fht_load_addr_map.sv
// Combinational sample index -> {bank, addr}; FHT_LOAD_BITREV_EN selects bit-reversed
// (decimation-in-time) order, otherwise natural order.
module fht_load_addr_map
   import fht_pkg::*;
#(
   parameter int A_BIT = 8
) (
   input  logic [A_BIT+1:0] idx,
   output logic [1:0]       bank,
   output logic [A_BIT-1:0] addr
);

   localparam int IW = A_BIT + 2;

   logic [IW-1:0] r;

`ifdef FHT_LOAD_BITREV_EN
   assign r = IW'(bitrev(32'(idx), IW));
`else
   assign r = idx;
`endif

   assign bank = r[IW-1:A_BIT];
   assign addr = r[A_BIT-1:0];

endmodule

// File: rtl/fht_input_loader.sv
// Streams one N = 2^(A_BIT+2) sample frame into the four FHT banks (1-cycle write latency),
// then kicks fht_control and holds oREADY low until it reports done. Option: FHT_LOAD_BITREV_EN.
module fht_input_loader
   import fht_pkg::*;
#(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iDATA,
   input  logic             iVALID,
   input  logic             iSOP,
   output logic             oREADY,
   input  logic             iFHT_RDY,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA,
   output logic [3:0]       oWE,
   output logic             oSTART,
   output logic [7:0]       oDROP_CNT
);

   localparam int            IW       = A_BIT + 2;
   localparam logic [IW-1:0] IDX_LAST = '1;

   loader_state_t    state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_eff;
   logic [3:0]       retry_cnt;
   logic             xfer;
   logic             sop_drop;
   logic [1:0]       bank;
   logic [A_BIT-1:0] addr;

   assign oREADY   = (state == LOAD) & ~iRESET;
   assign xfer     = iVALID & oREADY;
   // A start marker in mid-frame abandons the partial frame and restarts at index 0.
   assign sop_drop = iSOP && (idx != '0);
   assign idx_eff  = sop_drop ? '0 : idx;

   fht_load_addr_map #(.A_BIT(A_BIT)) u_addr_map (
      .idx  (idx_eff),
      .bank (bank),
      .addr (addr)
   );

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state     <= LOAD;
         idx       <= '0;
         retry_cnt <= '0;
         oWE       <= '0;
         oSTART    <= 1'b0;
         oADDR_WR  <= '0;
         oDATA     <= '0;
         oDROP_CNT <= '0;
      end else begin
         oWE    <= '0;
         oSTART <= 1'b0;

         if (xfer) begin
            oWE      <= 4'b0001 << bank;
            oADDR_WR <= addr;
            oDATA    <= iDATA;
            if (sop_drop && (oDROP_CNT != 8'(DROP_MAX))) oDROP_CNT <= oDROP_CNT + 8'd1;
         end

         case (state)
            LOAD: begin
               if (xfer) begin
                  if (idx_eff == IDX_LAST) begin
                     idx    <= '0;
                     state  <= KICK;
                     oSTART <= 1'b1;
                  end else begin
                     idx <= idx_eff + 1'b1;
                  end
               end
            end
            KICK: begin
               retry_cnt <= '0;
               state     <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // fht_control never went busy: assume the start was missed and pulse again.
               if (!iFHT_RDY) begin
                  state <= WAIT_DONE;
               end else if (retry_cnt == 4'(START_RETRY - 1)) begin
                  state  <= KICK;
                  oSTART <= 1'b1;
               end else begin
                  retry_cnt <= retry_cnt + 4'd1;
               end
            end
            WAIT_DONE: begin
               if (iFHT_RDY) state <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader with A_BIT=2 (N=16); the driver pushes expected
// bank writes and start pulses, a negedge monitor pops and compares them.
module tb_fht_input_loader;

   localparam int AB = 2;
   localparam int DB = 16;
   localparam int N  = 4 << AB;

   logic          iCLK;
   logic          iRESET;
   logic [DB-1:0] iDATA;
   logic          iVALID;
   logic          iSOP;
   logic          oREADY;
   logic          iFHT_RDY;
   logic [AB-1:0] oADDR_WR;
   logic [DB-1:0] oDATA;
   logic [3:0]    oWE;
   logic          oSTART;
   logic [7:0]    oDROP_CNT;

   fht_input_loader #(.A_BIT(AB), .D_BIT(DB)) dut (
      .iCLK      (iCLK),
      .iRESET    (iRESET),
      .iDATA     (iDATA),
      .iVALID    (iVALID),
      .iSOP      (iSOP),
      .oREADY    (oREADY),
      .iFHT_RDY  (iFHT_RDY),
      .oADDR_WR  (oADDR_WR),
      .oDATA     (oDATA),
      .oWE       (oWE),
      .oSTART    (oSTART),
      .oDROP_CNT (oDROP_CNT)
   );

   typedef struct {
      int cyc;
      int bank;
      int addr;
      int data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_start[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   int  wr_cnt   = 0;
   int  m_idx    = 0;
   int  m_drop   = 0;
   int  n_frames = 0;
   int  last_start = 0;

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference placement of sample n: natural order, or bit-reversed over AB+2 bits.
   function automatic void place(input int n, output int bank, output int addr);
      int r;
      r = n;
`ifdef FHT_LOAD_BITREV_EN
      r = 0;
      for (int i = 0; i < AB + 2; i++)
         if (((n >> i) & 1) == 1) r = r | (1 << (AB + 1 - i));
`endif
      bank = r / (1 << AB);
      addr = r % (1 << AB);
   endfunction

   task automatic model_xfer(input int d, input bit sop);
      int  n;
      wr_t e;
      n = m_idx;
      if (sop && m_idx != 0) begin
         n = 0;
         if (m_drop < 255) m_drop++;
      end
      e.cyc  = cyc;
      e.data = d;
      place(n, e.bank, e.addr);
      exp_wr.push_back(e);
      if (n == N - 1) begin
         m_idx = 0;
         last_start = cyc;
         exp_start.push_back(cyc);
         n_frames++;
      end else begin
         m_idx = n + 1;
      end
   endtask

   // Must be called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int d, input bit sop, input int gap);
      bit rdy;
      repeat (gap) begin
         iVALID = 1'b0;
         iDATA  = DB'($urandom);
         iSOP   = 1'($urandom);
         @(posedge iCLK); #1;
      end
      iVALID = 1'b1;
      iDATA  = DB'(d);
      iSOP   = sop;
      for (int w = 0; w < 200; w++) begin
         @(negedge iCLK);
         rdy = oREADY;
         @(posedge iCLK); #1;
         if (rdy) begin
            model_xfer(d & 16'hffff, sop);
            iVALID = 1'b0;
            iSOP   = 1'b0;
            return;
         end
      end
      check("send_timeout", 0, 1);
      iVALID = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge iCLK); #1;
      end
   endtask

   // fht_control held busy for len cycles, then done; loader reopens one cycle later.
   task automatic fht_done(input int len);
      repeat (len) @(posedge iCLK);
      #1;
      @(negedge iCLK);
      check("ready_while_busy", oREADY, 0);
      @(posedge iCLK); #1;
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      check("ready_on_done_cycle", oREADY, 0);
      @(negedge iCLK);
      check("ready_after_done", oREADY, 1);
      @(posedge iCLK); #1;
   endtask

   task automatic busy_after_start(input int delay, input int len);
      wait_until(last_start + delay);
      iFHT_RDY = 1'b0;
      fht_done(len);
   endtask

   always @(negedge iCLK) begin
      while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
         check("write_missing", 0, exp_wr[0].data);
         void'(exp_wr.pop_front());
      end
      while (exp_start.size() > 0 && exp_start[0] < cyc) begin
         check("start_missing", 0, exp_start[0]);
         void'(exp_start.pop_front());
      end
      if (oWE != 4'd0) begin
         if (exp_wr.size() == 0 || exp_wr[0].cyc != cyc) begin
            check("write_unexpected", int'(oWE), 0);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("write_we", int'(oWE), 1 << e.bank);
            check("write_addr", int'(oADDR_WR), e.addr);
            check("write_data", int'(oDATA), e.data);
            check("drop_cnt", int'(oDROP_CNT), m_drop);
            wr_cnt++;
         end
      end
      if (oSTART) begin
         if (exp_start.size() == 0 || exp_start[0] != cyc) check("start_unexpected", cyc, -1);
         else check("start_cycle", cyc, exp_start.pop_front());
      end
   end

   initial begin
      int w0;
      int f0;
      int c;
      iRESET = 1'b1; iVALID = 1'b0; iDATA = '0; iSOP = 1'b0; iFHT_RDY = 1'b1;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check("ready_in_reset", oREADY, 0);
      @(posedge iCLK); #1;
      iRESET = 1'b0;
      @(negedge iCLK);
      check("rst_we", int'(oWE), 0);
      check("rst_start", int'(oSTART), 0);
      check("rst_addr", int'(oADDR_WR), 0);
      check("rst_data", int'(oDATA), 0);
      check("rst_drop", int'(oDROP_CNT), 0);
      check("rst_ready", oREADY, 1);
      @(posedge iCLK); #1;

      // Full-rate frame 0..15 with fht_control never going busy: start re-pulses.
      w0 = wr_cnt;
      for (int k = 0; k < N; k++) send(k, 1'b0, 0);
      c = last_start;
      exp_start.push_back(c + 9);
      exp_start.push_back(c + 18);
      @(negedge iCLK);
      check("ready_after_frame", oREADY, 0);
      @(posedge iCLK); #1;
      wait_until(c + 19);
      iFHT_RDY = 1'b0;
      fht_done(40);
      check("frame_write_count", wr_cnt - w0, N);

      // Gapped frame; fht_control goes busy 2 cycles after start for 40 cycles.
      w0 = wr_cnt;
      for (int k = 0; k < N; k++) send(int'($urandom), 1'b0, int'($urandom_range(0, 2)));
      busy_after_start(2, 40);
      check("gapped_write_count", wr_cnt - w0, N);

      // Start marker on the 6th sample restarts the frame at index 0.
      for (int k = 0; k < 5; k++) send(int'($urandom), 1'b0, 0);
      send(16'h5a5a, 1'b1, 0);
      for (int k = 1; k < N; k++) send(int'($urandom), 1'b0, 0);
      check("drop_after_sop", int'(oDROP_CNT), 1);
      busy_after_start(3, 10);

      // Random frames with gaps and occasional start markers anywhere.
      for (int f = 0; f < 4; f++) begin
         f0 = n_frames;
         for (int s = 0; s < 200 && n_frames == f0; s++)
            send(int'($urandom), ($urandom_range(0, 11) == 0), int'($urandom_range(0, 2)));
         check("random_frame_done", n_frames - f0, 1);
         busy_after_start(int'($urandom_range(1, 8)), int'($urandom_range(5, 30)));
      end

      // Reset after 9 samples discards the partial frame and clears the drop count.
      for (int k = 0; k < 9; k++) send(int'($urandom), 1'b0, 0);
      iRESET = 1'b1;
      @(negedge iCLK);
      check("ready_during_reset", oREADY, 0);
      @(posedge iCLK); #1;
      iRESET = 1'b0;
      m_idx  = 0;
      m_drop = 0;
      @(negedge iCLK);
      check("mid_rst_we", int'(oWE), 0);
      check("mid_rst_start", int'(oSTART), 0);
      check("mid_rst_addr", int'(oADDR_WR), 0);
      check("mid_rst_data", int'(oDATA), 0);
      check("mid_rst_drop", int'(oDROP_CNT), 0);
      check("mid_rst_ready", oREADY, 1);
      @(posedge iCLK); #1;
      f0 = n_frames;
      for (int k = 0; k < N; k++) send(int'($urandom), 1'b0, int'($urandom_range(0, 1)));
      check("fresh_frame_done", n_frames - f0, 1);
      busy_after_start(1, 12);
      check("fresh_drop", int'(oDROP_CNT), 0);

      repeat (4) @(posedge iCLK);
      #1;
      check("pending_writes", exp_wr.size(), 0);
      check("pending_starts", exp_start.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
